vga_timing: RTL and testbench



---
 rtl/vga_timing.sv | 173 +++++++++++++++++
 tb/tb_vga_timing.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// vga_timing: raster timing generator.
// Walks (h, v) across a full frame, one position per enabled clock, and drives registered
// position, display-enable, sync and start-of-frame outputs for the current position.
// Optional build macro VGA_TIMING_FRAME_CNT_EN adds an 8-bit frame counter output vga_FRAME.

`timescale 1ns/1ps

module vga_timing #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CW       = 11
) (
  input  logic          vga_CLK,
  input  logic          vga_RST,
  input  logic          vga_EN,
  output logic [CW-1:0] vga_X,
  output logic [CW-1:0] vga_Y,
  output logic          vga_DE,
  output logic          vga_HS,
  output logic          vga_VS,
  output logic          vga_SOF
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [7:0]    vga_FRAME
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Boundaries pre-cast to counter width so every compare is CW bits on both sides.
  localparam logic [CW-1:0] HLast     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VLast     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HActEnd   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VActEnd   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HSyncBeg  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HSyncEnd  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VSyncBeg  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VSyncEnd  = CW'(V_ACTIVE + V_FP + V_SYNC);

  // Position counters start on the last position so the first enabled edge lands on (0,0).
  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;

  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          de_q, de_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          sof_q, sof_d;

  logic          h_wrap;
  logic          v_wrap;
  logic          in_hact;
  logic          in_vact;
  logic          in_hsync;
  logic          in_vsync;
  logic          at_origin;

  // Next position: advance h, carry into v at end of line, wrap v at end of frame.
  always_comb begin
    h_d    = h_q;
    v_d    = v_q;
    h_wrap = (h_q == HLast);
    v_wrap = (v_q == VLast);
    if (vga_EN) begin
      if (h_wrap) begin
        h_d = '0;
        if (v_wrap) begin
          v_d = '0;
        end else begin
          v_d = v_q + CW'(1);
        end
      end else begin
        h_d = h_q + CW'(1);
      end
    end
  end

  // Decode the upcoming position so the registered outputs describe it on the same edge.
  always_comb begin
    in_hact   = (h_d < HActEnd);
    in_vact   = (v_d < VActEnd);
    in_hsync  = (h_d >= HSyncBeg) && (h_d < HSyncEnd);
    // v only moves when h wraps to 0, so VS can only change at x = 0.
    in_vsync  = (v_d >= VSyncBeg) && (v_d < VSyncEnd);
    at_origin = (h_d == '0) && (v_d == '0);

    x_d   = x_q;
    y_d   = y_q;
    de_d  = de_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    sof_d = 1'b0;
    if (vga_EN) begin
      x_d   = h_d;
      y_d   = v_d;
      de_d  = in_hact && in_vact;
      hs_d  = in_hsync ? HS_POL : ~HS_POL;
      vs_d  = in_vsync ? VS_POL : ~VS_POL;
      sof_d = at_origin;
    end
  end

  // Position counter state.
  always_ff @(posedge vga_CLK or posedge vga_RST) begin
    if (vga_RST) begin
      h_q <= HLast;
      v_q <= VLast;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Registered outputs; all inactive during reset.
  always_ff @(posedge vga_CLK or posedge vga_RST) begin
    if (vga_RST) begin
      x_q   <= '0;
      y_q   <= '0;
      de_q  <= 1'b0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      sof_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      de_q  <= de_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      sof_q <= sof_d;
    end
  end

  assign vga_X   = x_q;
  assign vga_Y   = y_q;
  assign vga_DE  = de_q;
  assign vga_HS  = hs_q;
  assign vga_VS  = vs_q;
  assign vga_SOF = sof_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] frame_q, frame_d;

  // Frame count bumps on the edge that raises SOF, so frame 1 reads 1.
  always_comb begin
    frame_d = frame_q;
    if (sof_d) begin
      frame_d = frame_q + 8'd1;
    end
  end

  // Frame counter state.
  always_ff @(posedge vga_CLK or posedge vga_RST) begin
    if (vga_RST) begin
      frame_q <= 8'd0;
    end else begin
      frame_q <= frame_d;
    end
  end

  assign vga_FRAME = frame_q;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Testbench for vga_timing: a default-sized instance for line-level timing and a tiny
// instance (opposite sync polarity) for frame-level behaviour, both checked every cycle
// against a position-index reference model.

`timescale 1ns/1ps

module tb_vga_timing;

  localparam int BCW = 11;
  localparam int SCW = 4;
  localparam int B_HT = 800;
  localparam int B_VT = 525;
  // Tiny raster: 8 x 6 positions per frame.
  localparam int S_HA = 4, S_HFP = 1, S_HS = 2, S_HBP = 1;
  localparam int S_VA = 3, S_VFP = 1, S_VS = 1, S_VBP = 1;
  localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;
  localparam int S_VT = S_VA + S_VFP + S_VS + S_VBP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_b = 1'b0;
  logic en_s = 1'b0;

  logic [BCW-1:0] b_x, b_y;
  logic           b_de, b_hs, b_vs, b_sof;
  logic [SCW-1:0] s_x, s_y;
  logic           s_de, s_hs, s_vs, s_sof;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0]     b_frame, s_frame;
`endif

  always #5 clk = ~clk;

  vga_timing u_big (
    .vga_CLK (clk),
    .vga_RST (rst),
    .vga_EN  (en_b),
    .vga_X   (b_x),
    .vga_Y   (b_y),
    .vga_DE  (b_de),
    .vga_HS  (b_hs),
    .vga_VS  (b_vs),
    .vga_SOF (b_sof)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    .vga_FRAME (b_frame)
`endif
  );

  vga_timing #(
    .H_ACTIVE (S_HA), .H_FP (S_HFP), .H_SYNC (S_HS), .H_BP (S_HBP),
    .V_ACTIVE (S_VA), .V_FP (S_VFP), .V_SYNC (S_VS), .V_BP (S_VBP),
    .HS_POL   (1'b1), .VS_POL (1'b1), .CW (SCW)
  ) u_small (
    .vga_CLK (clk),
    .vga_RST (rst),
    .vga_EN  (en_s),
    .vga_X   (s_x),
    .vga_Y   (s_y),
    .vga_DE  (s_de),
    .vga_HS  (s_hs),
    .vga_VS  (s_vs),
    .vga_SOF (s_sof)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    .vga_FRAME (s_frame)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int x;
    int y;
    bit de;
    bit hs;
    bit vs;
  } exp_t;

  // n = enabled edges since reset; position index n-1 within the frame.
  function automatic exp_t ref_pos(input longint n, input int ha, input int hfp, input int hsw,
                                   input int hbp, input int va, input int vfp, input int vsw,
                                   input int vbp, input bit hpol, input bit vpol);
    exp_t   e;
    int     ht;
    int     vt;
    longint p;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    if (n == 0) begin
      e.x = 0; e.y = 0; e.de = 1'b0; e.hs = !hpol; e.vs = !vpol;
      return e;
    end
    p    = (n - 1) % (ht * vt);
    e.x  = int'(p % ht);
    e.y  = int'(p / ht);
    e.de = (e.x < ha) && (e.y < va);
    e.hs = (e.x >= ha + hfp && e.x < ha + hfp + hsw) ? hpol : !hpol;
    e.vs = (e.y >= va + vfp && e.y < va + vfp + vsw) ? vpol : !vpol;
    return e;
  endfunction

  longint n_b = 0, n_s = 0;
  bit     sof_b_e = 1'b0, sof_s_e = 1'b0;
  int     frm_b_e = 0, frm_s_e = 0;

  task automatic model_edge();
    if (rst) begin
      n_b = 0; n_s = 0; sof_b_e = 1'b0; sof_s_e = 1'b0; frm_b_e = 0; frm_s_e = 0;
    end else begin
      sof_b_e = 1'b0;
      sof_s_e = 1'b0;
      if (en_b) begin
        n_b++;
        sof_b_e = ((n_b - 1) % (B_HT * B_VT) == 0);
      end
      if (en_s) begin
        n_s++;
        sof_s_e = ((n_s - 1) % (S_HT * S_VT) == 0);
      end
      if (sof_b_e) frm_b_e = (frm_b_e + 1) % 256;
      if (sof_s_e) frm_s_e = (frm_s_e + 1) % 256;
    end
  endtask

  task automatic check_now();
    exp_t eb;
    exp_t es;
    eb = ref_pos(n_b, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
    es = ref_pos(n_s, S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, 1'b1, 1'b1);
    check_eq("b_x",   32'(b_x),   eb.x);
    check_eq("b_y",   32'(b_y),   eb.y);
    check_eq("b_de",  32'(b_de),  32'(eb.de));
    check_eq("b_hs",  32'(b_hs),  32'(eb.hs));
    check_eq("b_vs",  32'(b_vs),  32'(eb.vs));
    check_eq("b_sof", 32'(b_sof), 32'(sof_b_e));
    check_eq("s_x",   32'(s_x),   es.x);
    check_eq("s_y",   32'(s_y),   es.y);
    check_eq("s_de",  32'(s_de),  32'(es.de));
    check_eq("s_hs",  32'(s_hs),  32'(es.hs));
    check_eq("s_vs",  32'(s_vs),  32'(es.vs));
    check_eq("s_sof", 32'(s_sof), 32'(sof_s_e));
`ifdef VGA_TIMING_FRAME_CNT_EN
    check_eq("b_frame", 32'(b_frame), frm_b_e);
    check_eq("s_frame", 32'(s_frame), frm_s_e);
`endif
  endtask

  // Inputs change on the falling edge; outputs are checked on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_now();
  endtask

  int hs_cnt = 0, hs_first = -1, hs_last = -1, de_fall = -1, wrap_y = -1;
  int prev_x = -1;
  bit hit;
  bit saw_wrap = 1'b0;
  int prev_frm = -1;

  initial begin
    // Reset held with enables high: edges must be ignored.
    rst = 1'b1; en_b = 1'b1; en_s = 1'b1;
    @(negedge clk);
    repeat (3) step();

    rst = 1'b0; en_b = 1'b1; en_s = 1'b1;
    step();
    check_eq("first_x",   32'(b_x),   0);
    check_eq("first_y",   32'(b_y),   0);
    check_eq("first_de",  32'(b_de),  1);
    check_eq("first_sof", 32'(b_sof), 1);
    step();
    check_eq("sof_width", 32'(b_sof), 0);

    // Line-level timing on line 0 with enable held high.
    prev_x = int'(b_x);
    for (int i = 0; i < 1700; i++) begin
      en_s = ($urandom_range(0, 1) != 0);
      step();
      if (b_y == 0) begin
        if (!b_hs) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = int'(b_x);
          hs_last = int'(b_x);
        end
        if (!b_de && de_fall < 0) de_fall = int'(b_x);
      end
      if (prev_x == 799 && b_x == 0 && wrap_y < 0) wrap_y = int'(b_y);
      prev_x = int'(b_x);
    end
    check_eq("hs_first", hs_first, 656);
    check_eq("hs_last",  hs_last,  751);
    check_eq("hs_width", hs_cnt,   96);
    check_eq("de_fall",  de_fall,  640);
    check_eq("wrap_y",   wrap_y,   1);

    // Enable toggling 1,0,1,0 on both instances.
    for (int i = 0; i < 200; i++) begin
      en_b = (i % 2 == 0);
      en_s = (i % 2 == 0);
      step();
    end

    // Advance to X = 300 and reset mid-line.
    en_b = 1'b1;
    hit = (b_x == 300);
    for (int i = 0; i < 2000 && !hit; i++) begin
      step();
      hit = (b_x == 300);
    end
    check_eq("reach_x300", 32'(hit), 1);
    rst = 1'b1;
    #1;
    model_edge();
    check_now();
    check_eq("rst_async_x", 32'(b_x), 0);
    repeat (3) step();
    rst = 1'b0; en_b = 1'b1; en_s = 1'b1;
    step();
    check_eq("rel_x",   32'(b_x),   0);
    check_eq("rel_y",   32'(b_y),   0);
    check_eq("rel_sof", 32'(b_sof), 1);
    check_eq("rel_ssof", 32'(s_sof), 1);

    // Long randomized run: many tiny frames, frame counter wrap.
    for (int i = 0; i < 20000; i++) begin
      en_b = ($urandom_range(0, 3) != 0);
      en_s = ($urandom_range(0, 3) != 0);
      step();
`ifdef VGA_TIMING_FRAME_CNT_EN
      if (prev_frm == 255 && s_frame == 8'd0) saw_wrap = 1'b1;
      prev_frm = int'(s_frame);
`endif
    end
`ifdef VGA_TIMING_FRAME_CNT_EN
    check_eq("frm_wrap", 32'(saw_wrap), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
